// File: rtl/vlb_miss_tracker_if.sv
// rtl/vlb_miss_tracker_if.sv - miss, FST request/response/fill and VLB refill signal bundle
interface vlb_miss_tracker_if #(
  parameter int VPN_W = 52,
  parameter int MPN_W = 52
);
  logic             miss_i_valid;
  logic             miss_i_ready;
  logic [VPN_W-1:0] miss_i_bits_vpn;
  logic             miss_i_bits_spec;
  logic [1:0]       kill_i;
  logic             req_o_valid;
  logic [5:0]       req_o_bits_idx;
  logic [VPN_W-1:0] req_o_bits_vpn;
  logic             busy_i;
  logic             resp_i_valid;
  logic [5:0]       resp_i_bits_idx;
  logic             resp_i_bits_vld;
  logic             resp_i_bits_err;
  logic [MPN_W-1:0] resp_i_bits_mpn;
  logic [3:0]       resp_i_bits_attr;
  logic             fill_i_valid;
  logic [5:0]       fill_i_bits_idx;
  logic             fill_i_bits_vld;
  logic             fill_i_bits_err;
  logic [MPN_W-1:0] fill_i_bits_mpn;
  logic [3:0]       fill_i_bits_attr;
  logic             refill_o_valid;
  logic [VPN_W-1:0] refill_o_bits_vpn;
  logic             refill_o_bits_vld;
  logic             refill_o_bits_err;
  logic [MPN_W-1:0] refill_o_bits_mpn;
  logic [3:0]       refill_o_bits_attr;
  logic             busy_o;

  modport slave (
    input  miss_i_valid, miss_i_bits_vpn, miss_i_bits_spec, kill_i, busy_i,
    input  resp_i_valid, resp_i_bits_idx, resp_i_bits_vld, resp_i_bits_err,
    input  resp_i_bits_mpn, resp_i_bits_attr,
    input  fill_i_valid, fill_i_bits_idx, fill_i_bits_vld, fill_i_bits_err,
    input  fill_i_bits_mpn, fill_i_bits_attr,
    output miss_i_ready, req_o_valid, req_o_bits_idx, req_o_bits_vpn,
    output refill_o_valid, refill_o_bits_vpn, refill_o_bits_vld, refill_o_bits_err,
    output refill_o_bits_mpn, refill_o_bits_attr, busy_o
  );

  modport master (
    output miss_i_valid, miss_i_bits_vpn, miss_i_bits_spec, kill_i, busy_i,
    output resp_i_valid, resp_i_bits_idx, resp_i_bits_vld, resp_i_bits_err,
    output resp_i_bits_mpn, resp_i_bits_attr,
    output fill_i_valid, fill_i_bits_idx, fill_i_bits_vld, fill_i_bits_err,
    output fill_i_bits_mpn, fill_i_bits_attr,
    input  miss_i_ready, req_o_valid, req_o_bits_idx, req_o_bits_vpn,
    input  refill_o_valid, refill_o_bits_vpn, refill_o_bits_vld, refill_o_bits_err,
    input  refill_o_bits_mpn, refill_o_bits_attr, busy_o
  );
endinterface

// File: rtl/vlb_miss_tracker.sv
// rtl/vlb_miss_tracker.sv - per-port VLB miss tracker with merge, issue, fill collection and kill
module vlb_miss_tracker #(
  parameter int N     = 8,
  parameter int VPN_W = 52,
  parameter int MPN_W = 52,
  parameter int PORT  = 0
) (
  input logic               clock,
  input logic               reset,
  vlb_miss_tracker_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {FREE, PEND, WAIT, RDY, DEAD} ent_state_t;

  ent_state_t       st_q   [N];
  ent_state_t       st_d   [N];
  logic [VPN_W-1:0] vpn_q  [N];
  logic             spec_q [N];
  logic             vld_q  [N];
  logic             err_q  [N];
  logic [MPN_W-1:0] mpn_q  [N];
  logic [3:0]       attr_q [N];

  logic [N-1:0]  hit, take_resp, take_fill, alloc;
  logic          match, free_any, pend_any, rdy_any, any_used;
  logic          kill_any, miss_fire, req_v, refill_v;
  logic [IW-1:0] free_idx, pend_idx, rdy_idx;
  logic          rh, fh, kl;

  // Live-entry VPN match vector and lowest-index FREE/PEND/RDY search.
  always_comb begin
    hit      = '0;
    free_any = 1'b0;
    pend_any = 1'b0;
    rdy_any  = 1'b0;
    any_used = 1'b0;
    free_idx = '0;
    pend_idx = '0;
    rdy_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((st_q[i] == PEND || st_q[i] == WAIT || st_q[i] == RDY) &&
          vpn_q[i] == bus.miss_i_bits_vpn)
        hit[i] = 1'b1;
      if (st_q[i] == FREE) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end else begin
        any_used = 1'b1;
      end
      if (st_q[i] == PEND) begin
        pend_any = 1'b1;
        pend_idx = IW'(i);
      end
      if (st_q[i] == RDY) begin
        rdy_any = 1'b1;
        rdy_idx = IW'(i);
      end
    end
  end

  assign match     = |hit;
  assign kill_any  = |bus.kill_i;
  assign miss_fire = bus.miss_i_valid & bus.miss_i_ready;
  assign req_v     = ~reset & pend_any & ~bus.busy_i & ~kill_any;
  assign refill_v  = ~reset & rdy_any & ~kill_any;

  // All outputs are held at zero while reset is asserted, even before the state clears.
  assign bus.miss_i_ready       = ~reset & (match | free_any) & ~kill_any;
  assign bus.busy_o             = ~reset & any_used;
  assign bus.req_o_valid        = req_v;
  assign bus.req_o_bits_idx     = req_v ? {1'(PORT), 5'(pend_idx)} : 6'd0;
  assign bus.req_o_bits_vpn     = req_v ? vpn_q[pend_idx] : '0;
  assign bus.refill_o_valid     = refill_v;
  assign bus.refill_o_bits_vpn  = refill_v ? vpn_q[rdy_idx] : '0;
  assign bus.refill_o_bits_vld  = refill_v & vld_q[rdy_idx];
  assign bus.refill_o_bits_err  = refill_v & err_q[rdy_idx];
  assign bus.refill_o_bits_mpn  = refill_v ? mpn_q[rdy_idx] : '0;
  assign bus.refill_o_bits_attr = refill_v ? attr_q[rdy_idx] : 4'd0;

  // Per-entry next state: refill, resp/fill, issue, allocation, then kill last.
  always_comb begin
    take_resp = '0;
    take_fill = '0;
    alloc     = '0;
    rh        = 1'b0;
    fh        = 1'b0;
    kl        = 1'b0;
    for (int i = 0; i < N; i++) begin
      st_d[i] = st_q[i];
      rh = bus.resp_i_valid && bus.resp_i_bits_idx == {1'(PORT), 5'(i)};
      fh = bus.fill_i_valid && bus.fill_i_bits_idx == {1'(PORT), 5'(i)};
      kl = bus.kill_i[1] || (bus.kill_i[0] && spec_q[i]);
      if (refill_v && rdy_idx == IW'(i))
        st_d[i] = FREE;
      if (rh && bus.resp_i_bits_vld) begin
        if (st_q[i] == WAIT) begin
          st_d[i]      = RDY;
          take_resp[i] = 1'b1;
        end else if (st_q[i] == DEAD) begin
          st_d[i] = FREE;
        end
      end
      // A fill colliding with a completing resp on the same entry is dropped.
      if (fh && !take_resp[i]) begin
        if (st_q[i] == WAIT) begin
          st_d[i]      = RDY;
          take_fill[i] = 1'b1;
        end else if (st_q[i] == DEAD) begin
          st_d[i] = FREE;
        end
      end
      if (req_v && pend_idx == IW'(i))
        st_d[i] = WAIT;
      if (miss_fire && !match && free_idx == IW'(i)) begin
        st_d[i]  = PEND;
        alloc[i] = 1'b1;
      end
      if (kl) begin
        case (st_d[i])
          PEND, RDY: st_d[i] = FREE;
          WAIT:      st_d[i] = DEAD;
          default:   st_d[i] = st_d[i];
        endcase
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++)
      st_q[i] <= reset ? FREE : st_d[i];
  end

  // Entry payload: VPN/spec on allocate or merge, result on resp or fill capture.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (alloc[i]) begin
        vpn_q[i]  <= bus.miss_i_bits_vpn;
        spec_q[i] <= bus.miss_i_bits_spec;
      end else if (miss_fire && hit[i]) begin
        spec_q[i] <= spec_q[i] & bus.miss_i_bits_spec;
      end
      if (take_resp[i]) begin
        vld_q[i]  <= bus.resp_i_bits_vld;
        err_q[i]  <= bus.resp_i_bits_err;
        mpn_q[i]  <= bus.resp_i_bits_mpn;
        attr_q[i] <= bus.resp_i_bits_attr;
      end else if (take_fill[i]) begin
        vld_q[i]  <= bus.fill_i_bits_vld;
        err_q[i]  <= bus.fill_i_bits_err;
        mpn_q[i]  <= bus.fill_i_bits_mpn;
        attr_q[i] <= bus.fill_i_bits_attr;
      end
    end
  end
endmodule

// File: doc/vlb_miss_tracker.md
# vlb_miss_tracker

Per-port miss tracker between a VLB lookup array and one request port of the FST translation engine. It accepts VLB misses, merges duplicates and issues `req_o` to FST with a tracker index. It collects the FST's immediate `resp_i` or deferred `fill_i`, retiring each translation to the VLB array on `refill_o`. Kills from the pipeline discard speculative or all outstanding work. Fills for killed entries that are already in flight are absorbed silently.

## Interface
- `N`, 8: tracker entries; power of 2, 2..32
- `VPN_W`, 52: virtual page number width
- `MPN_W`, 52: physical page number width
- `PORT`, 0: value carried in `idx[5]`; selects this tracker on the shared FST fill bus

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `miss_i_valid` in 1: VLB miss request
- `miss_i_ready` out 1: miss accepted this cycle
- `miss_i_bits_vpn` in VPN_W: missing VPN
- `miss_i_bits_spec` in 1: request is speculative
- `kill_i` in 2: [0] kill speculative entries, [1] kill all entries
- `req_o_valid` out 1: request to FST; FST provides no ready
- `req_o_bits_idx` out 6: {PORT, zero-extended entry index}
- `req_o_bits_vpn` out VPN_W: VPN of the issued entry
- `busy_i` in 1: FST cannot take a request from this port
- `resp_i_valid` in 1: FST immediate response
- `resp_i_bits_idx` in 6: index being answered
- `resp_i_bits_vld` in 1: 1 = translation is complete; 0 = a fill will follow
- `resp_i_bits_err`, `resp_i_bits_mpn`, `resp_i_bits_attr` in 1/MPN_W/4: translation result
- `fill_i_valid`, `fill_i_bits_idx`, `fill_i_bits_vld`, `fill_i_bits_err`, `fill_i_bits_mpn`, `fill_i_bits_attr` in 1/6/1/1/MPN_W/4: deferred result
- `refill_o_valid` out 1: write a result into the VLB array; always accepted
- `refill_o_bits_vpn`, `refill_o_bits_vld`, `refill_o_bits_err`, `refill_o_bits_mpn`, `refill_o_bits_attr` out VPN_W/1/1/MPN_W/4: result fields
- `busy_o` out 1: at least one entry is not FREE

## Operation
- Each entry has a state plus `vpn`, `spec` and result fields. States:
  - FREE: unused
  - PEND: accepted, not yet issued
  - WAIT: issued, awaiting `resp_i`/`fill_i`
  - RDY: result stored, awaiting `refill_o`
  - DEAD: killed while a result is still owed by FST
- Merge on a new miss:
  - Applies when the VPN matches a PEND, WAIT or RDY entry.
  - No new entry is allocated; the matched `spec` becomes `spec & miss_spec`.
- Allocation: when there is no match, the lowest-index FREE entry goes to PEND.
- `miss_i_ready` = (match | any FREE) & ~|kill_i.
- Issue:
  - Condition: `~busy_i & ~|kill_i` and some PEND entry exists.
  - The lowest-index PEND entry is issued and moves to WAIT.
  - At most one issue per cycle.
- `resp_i` / `fill_i` handling, applied only when `idx[5]==PORT`:
  - WAIT + resp vld=1 → RDY, result stored.
  - WAIT + resp vld=0 → stays WAIT.
  - WAIT + fill → RDY, storing the fill fields.
  - DEAD + resp vld=1, or DEAD + fill → FREE.
  - Any other state, or `idx[5]!=PORT` → ignored.
- `resp_i` and `fill_i` may both be valid in one cycle for different indices; both are applied.
- Refill:
  - The lowest-index RDY entry drives `refill_o`, one per cycle.
  - That entry becomes FREE at the next edge.
- Kill in cycle T, selecting all entries (`kill_i[1]`) or `spec` entries (`kill_i[0]`):
  - PEND → FREE, RDY → FREE, WAIT → DEAD.
  - `req_o_valid` and `refill_o_valid` are forced to 0 in T.
  - Kill is evaluated after the resp/fill update of cycle T, so a WAIT entry that receives a fill in T is freed.
- A RDY entry is never overwritten. A duplicate fill to RDY is ignored.

## Timing
- Reset: all entries FREE; `miss_i_ready`=0 during reset; all other outputs 0 (`req_o_*`, `refill_o_*`, `busy_o`).
- Miss accepted at T → entry PEND at T+1 → `req_o_valid` at T+1 at the earliest.
- `req_o_*` are combinational from entry state and `busy_i`/`kill_i`.
- Entries never leave WAIT on a timeout.
- Result at T → RDY at T+1 → `refill_o_valid` at T+1 → FREE at T+2.
- Throughput: one allocation, one issue and one refill per cycle, concurrently.
- Full: with all N entries non-FREE, a non-matching miss stalls (`miss_i_ready`=0); a matching miss is still accepted.
- Index wrap: `idx[4:0]` ≥ N is ignored.

## Test plan
- Basic flow:
  - Stimulus: miss vpn=0x123 at cycle 5; resp at cycle 7 with idx={PORT,0}, vld=1, mpn=0x456, attr=0x3.
  - Required: `req_o` at cycle 6 with idx=0; `refill_o` at cycle 8 with mpn=0x456; `busy_o`=0 at cycle 9.
- Deferred fill:
  - Stimulus: resp vld=0, then a fill 20 cycles later carrying err=1.
  - Required: exactly one `refill_o` with err=1; no `refill_o` after the resp.
- Merge and full:
  - Stimulus: with N=8, eight distinct misses with `busy_i`=1; then a 9th distinct miss and a repeat of vpn #3.
  - Required: 9th stalls; repeat accepted; no new `req_o`.
- Speculative kill:
  - Stimulus: two entries in WAIT (spec=1 and spec=0); pulse `kill_i`=01; deliver fills for both.
  - Required: the spec entry becomes DEAD and is freed silently; only the non-spec entry refills.
- Cross-port fill:
  - Stimulus: fill with `idx[5]`=~PORT and a matching low index.
  - Required: ignored; the entry stays WAIT.
- Reset mid-operation:
  - Stimulus: assert `reset` with 4 entries in WAIT.
  - Required: all outputs 0 on the next cycle; stale fills arriving after reset produce no `refill_o`.
